// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC among sequential,
// branch, jump and exception sources, and presents the fetched word to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic [31:0] pc_plus4_F,
  output logic        valid_F,
  output logic        misalign,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [31:0] raw_target;
  logic        valid;
  logic [31:0] pc_seq;

  assign pc_seq = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = 1'b0;
    redirect      = 1'b0;
    raw_target    = EXC_VECTOR;
    valid         = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (exception) begin
          redirect   = 1'b1;
          raw_target = EXC_VECTOR;
        end
      end
      RUN: begin
        if (exception) begin
          redirect   = 1'b1;
          raw_target = EXC_VECTOR;
        end else if (branch_taken) begin
          redirect   = 1'b1;
          raw_target = branch_target;
        end else if (jump) begin
          redirect   = 1'b1;
          raw_target = jump_target;
        end
        // A redirect squashes the word already on the wrong path.
        valid = !redirect;
        if (!redirect && !stall) begin
          pc_d          = pc_seq;
          fetch_count_d = fetch_count_q + 32'd1;
          if (halt_req) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        // Only a trap or resume leaves HALT; control-flow requests are dropped.
        if (exception) begin
          redirect   = 1'b1;
          raw_target = EXC_VECTOR;
          state_d    = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (redirect) begin
      pc_d       = {raw_target[31:2], 2'b00};
      misalign_d = |raw_target[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_F        = pc_q;
  assign pc_plus4_F  = pc_seq;
  assign valid_F     = valid;
  assign instr_F     = valid ? imem_data : NOP_INSTR;
  assign misalign    = misalign_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each step pushes the expected fetch-side
// view, captures the DUT view, and each scenario task compares its own queue.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MKEY = 32'h1357_9BDF;
  localparam logic        O    = 1'b0;
  localparam logic        I    = 1'b1;
  localparam logic [31:0] Z    = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic        halt_req;
  logic        resume;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] pc_plus4_F;
  logic        valid_F;
  logic        misalign;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        v;
    logic        mis;
    logic        hlt;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_vec;
  int   n_err;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_data    (imem_data),
    .imem_addr    (imem_addr),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .exception    (exception),
    .halt_req     (halt_req),
    .resume       (resume),
    .instr_F      (instr_F),
    .pc_F         (pc_F),
    .pc_plus4_F   (pc_plus4_F),
    .valid_F      (valid_F),
    .misalign     (misalign),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  // Instruction memory: word content derived from its address.
  assign imem_data = imem_addr ^ MKEY;

  always #5 clk = ~clk;

  task automatic snap(input logic [31:0] epc, input logic ev, input logic [31:0] ecnt,
                      input logic emis, input logic ehlt);
    obs_t e;
    obs_t o;
    e.pc    = epc;
    e.addr  = epc;
    e.instr = ev ? (epc ^ MKEY) : NOP;
    e.pc4   = epc + 32'd4;
    e.cnt   = ecnt;
    e.v     = ev;
    e.mis   = emis;
    e.hlt   = ehlt;
    exp_q.push_back(e);
    o.pc    = pc_F;
    o.addr  = imem_addr;
    o.instr = instr_F;
    o.pc4   = pc_plus4_F;
    o.cnt   = fetch_count;
    o.v     = valid_F;
    o.mis   = misalign;
    o.hlt   = halted;
    obs_q.push_back(o);
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic ex, input logic hr, input logic rs,
                      input logic [31:0] epc, input logic ev, input logic [31:0] ecnt,
                      input logic emis, input logic ehlt);
    @(negedge clk);
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    exception     = ex;
    halt_req      = hr;
    resume        = rs;
    #1;
    snap(epc, ev, ecnt, emis, ehlt);
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t o;
    int   k;
    @(negedge clk);
    #1;
    snap(Z, O, Z, O, O);
    reset = I;
    #1;
    snap(Z, O, Z, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h0, I, 32'd0, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h4, I, 32'd1, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h8, I, 32'd2, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  task automatic test_stall();
    obs_t e;
    obs_t o;
    int   k;
    step(O,O,Z,O,Z,O,O,O, 32'hC,  I, 32'd3, O, O);
    step(I,O,Z,O,Z,O,O,O, 32'h10, I, 32'd4, O, O);
    step(I,O,Z,O,Z,O,O,O, 32'h10, I, 32'd4, O, O);
    step(I,O,Z,O,Z,O,O,O, 32'h10, I, 32'd4, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h10, I, 32'd4, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h14, I, 32'd5, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  task automatic test_branch_stall();
    obs_t e;
    obs_t o;
    int   k;
    step(O,O,Z,O,Z,O,O,O, 32'h18, I, 32'd6, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h1C, I, 32'd7, O, O);
    // Misaligned branch during a stall: redirect wins, squashes this word.
    step(I,I,32'h103,O,Z,O,O,O, 32'h20, O, 32'd8, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h100, I, 32'd8, I, O);
    step(O,O,Z,I,32'h40,O,O,O, 32'h104, O, 32'd9, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL branch_stall[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  task automatic test_priority();
    obs_t e;
    obs_t o;
    int   k;
    step(O,I,32'h200,I,32'h300,O,O,O, 32'h40, O, 32'd9, O, O);
    // Exception beats a misaligned branch, so no misalign pulse follows.
    step(O,I,32'h401,O,Z,I,O,O, 32'h200, O, 32'd9, O, O);
    step(O,O,Z,I,32'h50,O,O,O, 32'h80, O, 32'd9, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL priority[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  task automatic test_halt();
    obs_t e;
    obs_t o;
    int   k;
    step(O,O,Z,O,Z,O,I,O, 32'h50, I, 32'd9, O, O);
    step(O,I,32'h702,I,32'h601,O,I,O, 32'h54, O, 32'd10, O, I);
    step(O,O,Z,O,Z,I,O,I, 32'h54, O, 32'd10, O, I);
    step(O,O,Z,O,Z,O,O,O, 32'h80, I, 32'd10, O, O);
    step(O,O,Z,O,Z,O,I,O, 32'h84, I, 32'd11, O, O);
    step(O,O,Z,O,Z,O,O,I, 32'h88, O, 32'd12, O, I);
    step(I,O,Z,O,Z,O,I,O, 32'h88, I, 32'd12, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h88, I, 32'd12, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL halt[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  task automatic test_wrap_and_reset();
    obs_t e;
    obs_t o;
    int   k;
    step(O,O,Z,I,32'hFFFF_FFF8,O,O,O, 32'h8C, O, 32'd13, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'hFFFF_FFF8, I, 32'd13, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'hFFFF_FFFC, I, 32'd14, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h0, I, 32'd15, O, O);
    #2;
    reset = O;
    #1;
    snap(Z, O, Z, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap_reset[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  task automatic test_boot_exception();
    obs_t e;
    obs_t o;
    int   k;
    @(negedge clk);
    exception = I;
    reset     = I;
    #1;
    snap(Z, O, Z, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h80, I, 32'd0, O, O);
    step(O,O,Z,O,Z,O,O,O, 32'h84, I, 32'd1, O, O);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL boot_exception[%0d]: got pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b, expected pc=%h addr=%h instr=%h pc4=%h cnt=%0d v=%b mis=%b hlt=%b",
                 k, o.pc, o.addr, o.instr, o.pc4, o.cnt, o.v, o.mis, o.hlt, e.pc, e.addr, e.instr, e.pc4, e.cnt, e.v, e.mis, e.hlt);
      end
      k++;
    end
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    exception     = 1'b0;
    halt_req      = 1'b0;
    resume        = 1'b0;
    n_vec         = 0;
    n_err         = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_stall();
    test_branch_stall();
    test_priority();
    test_halt();
    test_wrap_and_reset();
    test_boot_exception();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
